scan_chain_controller: RTL and testbench
========================================

SCAN_CHAIN_CONTROLLER -- requirements
Module: scan_chain_controller

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 64: bit length of the attached scan chain; multiple of 8, minimum 8.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port start  input  1  request a full chain exchange; sampled in IDLE only.
REQ-005 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-006 The block SHALL have port done  output  1  one-cycle pulse when an exchange completes.
REQ-007 The block SHALL have port in_data  input  8  next byte to shift into the chain, MSB shifted first.
REQ-008 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): in_data handshake, transfer when both are high on a rising edge.
REQ-009 The block SHALL have port out_data  output  8  byte captured from the chain tail, first captured bit in bit 7.
REQ-010 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): out_data handshake, transfer when both are high on a rising edge.
REQ-011 The block SHALL have port scan_enable  output  1  drives the chain's scan_enable.
REQ-012 The block SHALL have port scan_in  output  1  drives the chain's serial input (enters at chain LSB).
REQ-013 The block SHALL have port scan_out  input  1  chain tail (chain MSB).
REQ-014 The block SHALL have port parity  output  1  XOR of all captured bits (see Configuration).

Function
REQ-015 The controller SHALL implement states IDLE, FETCH, SHIFT, EMIT, DONE.
REQ-016 In IDLE with start=1, next state SHALL be FETCH and the byte counter SHALL clear; start in any other state SHALL be ignored.
REQ-017 In FETCH, in_ready SHALL be 1; on transfer, in_data SHALL load the TX byte, the bit counter SHALL clear, next state SHALL be SHIFT.
REQ-018 In SHIFT, scan_enable SHALL be 1 for exactly 8 consecutive cycles, with scan_in = TX byte bit 7 and TX shifting left one bit per cycle.
REQ-019 On each SHIFT edge, scan_out SHALL be shifted into the LSB of the RX byte, so the first captured bit ends in bit 7.
REQ-020 After the 8th SHIFT cycle, next state SHALL be EMIT; out_valid SHALL be 1 and out_data SHALL hold the RX byte, both stable until transfer.
REQ-021 On EMIT transfer, the byte counter SHALL increment; next state SHALL be DONE if count reaches CHAIN_LEN/8, else FETCH.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 scan_enable SHALL be 0 in every state except SHIFT; stalls on in_valid or out_ready SHALL therefore never shift the chain.
REQ-024 in_ready SHALL be 0 outside FETCH and out_valid SHALL be 0 outside EMIT.
REQ-025 A full exchange with no stalls SHALL take exactly 1 + (CHAIN_LEN/8)*10 + 1 cycles from start accepted to done.
REQ-026 After a completed exchange, the chain SHALL hold the supplied bytes: first byte's bit 7 at chain MSB; RX bytes SHALL equal the prior chain contents MSB-first.

Reset
REQ-027 Asserting rst SHALL immediately force IDLE and clear counters, TX, RX, and parity, regardless of state, including mid-SHIFT.
REQ-028 While in reset and after release: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, scan_enable=0, scan_in=0, parity=0.
REQ-029 A reset mid-exchange SHALL discard the partial transfer; the chain keeps whatever bits were shifted.

Configuration
REQ-030 With macro SCAN_PARITY_CHECK_EN defined, parity SHALL clear on start acceptance, XOR in each captured bit, and hold its final value from done until the next start.
REQ-031 With SCAN_PARITY_CHECK_EN undefined, the parity port SHALL remain present and be tied to 0, and no parity logic SHALL be built.

Verification
REQ-032 The bench SHALL cover: CHAIN_LEN=16, chain preloaded 0xA5C3, inputs 0x12,0x34, no stalls -> outputs 0xA5,0xC3, chain 0x1234, done at cycle 22.
REQ-033 The bench SHALL cover: in_valid held low 5 cycles in FETCH -> scan_enable stays 0, chain unchanged, completion delayed exactly 5 cycles.
REQ-034 The bench SHALL cover: out_ready low 3 cycles in EMIT -> out_data stable, no shifting, next FETCH delayed 3 cycles.
REQ-035 The bench SHALL cover: rst pulsed after 3rd SHIFT cycle -> all outputs at reset values asynchronously, next start runs a full correct exchange.
REQ-036 The bench SHALL cover: start pulsed while busy -> ignored, exactly one done.
REQ-037 The bench SHALL cover: SCAN_PARITY_CHECK_EN defined, chain 0xA5C3 -> parity=0 at done; chain 0xA5C2 -> parity=1; macro undefined -> parity always 0.

Source files
------------

// File: rtl/scan_chain_if.sv
// Byte-stream handshake bundle between a host and the scan chain controller.
// The host drives bytes in and accepts captured bytes out; the controller
// is the slave on both streams.
interface scan_chain_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/scan_chain_controller.sv
// Scan chain controller: exchanges a full CHAIN_LEN-bit chain one byte at a
// time. Each byte is fetched from the host, shifted in MSB-first over eight
// scan cycles while the chain tail is captured, then offered back to the host.
// Optional build macro SCAN_PARITY_CHECK_EN adds a running XOR of every
// captured bit; without it the parity port is tied low.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | waiting for the next TX byte from the host
// SHIFT | eight scan cycles, one bit in and one bit out per cycle
// EMIT  | captured byte held on out_data until the host accepts it
// DONE  | one-cycle completion pulse
module scan_chain_controller #(
  parameter int CHAIN_LEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          scan_enable,
  output logic          scan_in,
  input  logic          scan_out,
  output logic          parity,
  scan_chain_if.slave   bus
);

  localparam int NUM_BYTES = CHAIN_LEN / 8;
  localparam int BCW       = $clog2(NUM_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    EMIT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       tx_byte;
  logic [7:0]       rx_byte;
  logic [2:0]       bit_cnt;
  logic [BCW-1:0]   byte_cnt;
  logic             last_byte;

  assign last_byte    = (byte_cnt == BCW'(NUM_BYTES - 1));
  assign busy         = (state != IDLE);
  assign scan_in      = (state == SHIFT) & tx_byte[7];
  assign bus.out_data = rx_byte;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake/scan strobes, all decoded from the current state.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    scan_enable   = 1'b0;
    done          = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        scan_enable = 1'b1;
        if (bit_cnt == 3'd7) state_next = EMIT;
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = last_byte ? DONE : FETCH;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte/bit counters and the TX/RX shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_byte  <= '0;
      rx_byte  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) byte_cnt <= '0;
        end
        FETCH: begin
          if (bus.in_valid) begin
            tx_byte <= bus.in_data;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          tx_byte <= {tx_byte[6:0], 1'b0};
          rx_byte <= {rx_byte[6:0], scan_out};
          bit_cnt <= bit_cnt + 3'd1;
        end
        EMIT: begin
          if (bus.out_ready) byte_cnt <= byte_cnt + BCW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SCAN_PARITY_CHECK_EN
  logic parity_q;

  // Running XOR of captured bits; restarts on start acceptance and otherwise
  // holds, so the value seen at done persists until the next exchange.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         parity_q <= 1'b0;
    else if (state == IDLE && start) parity_q <= 1'b0;
    else if (state == SHIFT)         parity_q <= parity_q ^ scan_out;
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_controller.sv
// Directed bench for scan_chain_controller with a 16-bit behavioural scan
// chain attached. Expected values are hand-computed per step.
module tb_scan_chain_controller;

`ifdef SCAN_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, scan_enable, scan_in, scan_out, parity;
  logic [15:0] chain = 16'h0000;
  logic [15:0] pre_val = 16'h0000;
  logic        pre_req = 1'b0;
  int          total = 0;
  int          passed = 0;

  scan_chain_if bus ();

  scan_chain_controller #(.CHAIN_LEN(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .parity      (parity),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Behavioural scan chain: shifts toward the MSB, scan_in enters at the LSB.
  always @(posedge clk) begin
    if (pre_req)          chain <= pre_val;
    else if (scan_enable) chain <= {chain[14:0], scan_in};
  end
  assign scan_out = chain[15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {busy, done, bus.in_ready, bus.out_valid, scan_enable, scan_in, parity, bus.out_data}, 32'h0);
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic preload(input logic [15:0] v);
    pre_val = v;
    pre_req = 1'b1;
    @(negedge clk);
    pre_req = 1'b0;
  endtask

  // Runs one exchange as the host, with optional stalls on the first byte and
  // optional start pulses while busy. Start cycle is cycle 1.
  task automatic exchange(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] e0, input logic [7:0] e1,
                          input logic [15:0] exp_chain, input int fetch_wait,
                          input int emit_wait, input int exp_cyc,
                          input logic exp_par, input bit glitch);
    logic [7:0]  tx_b [2];
    logic [7:0]  ex_b [2];
    logic [15:0] saved;
    int          cyc, done_cyc, in_idx, out_idx, fw, ew;
    tx_b[0] = b0; tx_b[1] = b1;
    ex_b[0] = e0; ex_b[1] = e1;
    saved = chain;
    fw = fetch_wait; ew = emit_wait;
    in_idx = 0; out_idx = 0; done_cyc = 0;
    cyc = 1;
    start = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      cyc++;
      start = glitch && (cyc == 5 || cyc == 15);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (bus.in_ready) begin
        if (in_idx == 0 && fw > 0) begin
          bus.in_valid = 1'b0;
          fw--;
          check("fetch_stall_se", {31'd0, scan_enable}, 32'd0);
          check("fetch_stall_chain", {16'd0, chain}, {16'd0, saved});
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = tx_b[in_idx];
          in_idx++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        if (out_idx == 0 && ew > 0) begin
          bus.out_ready = 1'b0;
          ew--;
          check("emit_stall_data", {24'd0, bus.out_data}, {24'd0, ex_b[0]});
          check("emit_stall_se", {31'd0, scan_enable}, 32'd0);
        end else begin
          bus.out_ready = 1'b1;
          check(out_idx == 0 ? "out_byte0" : "out_byte1", {24'd0, bus.out_data}, {24'd0, ex_b[out_idx]});
          out_idx++;
        end
      end else begin
        bus.out_ready = 1'b0;
      end
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("done_cycle", done_cyc, exp_cyc);
    check("busy_at_done", {31'd0, busy}, 32'd1);
    check("parity_at_done", {31'd0, parity}, {31'd0, exp_par & PAR_EN});
    @(negedge clk);
    check("chain_after", {16'd0, chain}, {16'd0, exp_chain});
    check("idle_after", {30'd0, busy, done}, 32'd0);
    check("parity_hold", {31'd0, parity}, {31'd0, exp_par & PAR_EN});
  endtask

  initial begin
    int dones;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset behaviour
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("in_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Basic exchange: 0xA5C3 out, 0x1234 in, parity of 0xA5C3 is 0
    preload(16'hA5C3);
    exchange(8'h12, 8'h34, 8'hA5, 8'hC3, 16'h1234, 0, 0, 22, 1'b0, 1'b0);

    // in_valid stall of 5 cycles; 0xA5C2 has odd parity
    preload(16'hA5C2);
    exchange(8'h56, 8'h78, 8'hA5, 8'hC2, 16'h5678, 5, 0, 27, 1'b1, 1'b0);

    // out_ready stall of 3 cycles; 0x5678 has 8 ones
    exchange(8'h9A, 8'hBC, 8'h56, 8'h78, 16'h9ABC, 0, 3, 25, 1'b0, 1'b0);

    // Reset after the 3rd shift of 0xF0: chain 0x9ABC -> 0xD5E7
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_fetch", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hF0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_shift", {31'd0, scan_enable}, 32'd1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_abort");
    check("chain_partial", {16'd0, chain}, 32'h0000D5E7);
    exchange(8'h0F, 8'hF0, 8'hD5, 8'hE7, 16'h0FF0, 0, 0, 22, 1'b1, 1'b0);

    // start pulsed while busy must not spawn a second exchange
    exchange(8'h11, 8'h22, 8'h0F, 8'hF0, 16'h1122, 0, 0, 22, 1'b0, 1'b1);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_extra_done", dones, 0);
    check("idle_final", {31'd0, busy}, 32'd0);
    check("chain_final", {16'd0, chain}, 32'h00001122);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
